// File: rtl/upscale_pkg.sv
// ---------------------------------------------------------------------------
// upscale_pkg
//   Shared types and size helpers for the 2x2 upscale frame sequencer.
//   ctrl_state_t : frame sequencer states
//   IN_PIX       : input pixels per frame  (h * v)
//   OUT_PIX      : output pixels per frame (4 * h * v, each input becomes 2x2)
// ---------------------------------------------------------------------------
package upscale_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  function automatic int IN_PIX(input int h, input int v);
    return h * v;
  endfunction

  function automatic int OUT_PIX(input int h, input int v);
    return 4 * h * v;
  endfunction

endpackage

// File: rtl/upscale_frame_ctrl_pos_counter.sv
// ---------------------------------------------------------------------------
// frame_pos_counter
//   Raster position of the output pixel stream. Column runs 0..width-1, row
//   runs 0..height-1, advancing by one column per inc. The flags describe the
//   pixel at the current position, i.e. the one about to be emitted.
// Ports
//   clk   in  system clock, rising edge
//   reset in  synchronous, active-high
//   clr   in  return to (0,0) at the start of a frame
//   inc   in  one pixel emitted at the current position
//   sof   out current position is column 0, row 0
//   eol   out current position is the last column of a row
// ---------------------------------------------------------------------------
module frame_pos_counter #(
  parameter int width  = 8,
  parameter int height = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic sof,
  output logic eol
);

  localparam int CW = (width  > 1) ? $clog2(width)  : 1;
  localparam int RW = (height > 1) ? $clog2(height) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(height - 1);

  logic [CW-1:0] ocol;
  logic [RW-1:0] orow;

  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // only seen on a rising edge; all state updates use non-blocking assigns.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ocol <= '0;
      orow <= '0;
    end else if (inc) begin
      if (ocol == COL_LAST) begin
        ocol <= '0;
        orow <= (orow == ROW_LAST) ? '0 : orow + 1'b1;
      end else begin
        ocol <= ocol + 1'b1;
      end
    end
  end

  assign sof = (ocol == '0) && (orow == '0);
  assign eol = (ocol == COL_LAST);

endmodule

// File: rtl/upscale_frame_ctrl.sv
// ---------------------------------------------------------------------------
// upscale_frame_ctrl
//   Frame sequencer for three lockstep single-channel 2x2 upscale cores.
//   Feeds packed {R,G,B} input pixels to all cores at once, collects their
//   outputs into one registered RGB stream tagged with SOF/EOL, counts frame
//   completion and flags channel desync, over-length frames and drain stalls.
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   start, abort               begin frame (IDLE only) / cancel (any state)
//   busy, frame_done, err      status: not idle / end-of-frame pulse / sticky
//   s_valid, s_ready, s_data   input pixel stream {R,G,B}
//   core_rst                   reset to all cores (held in IDLE and ARM)
//   core_valid_in/data_in      pixel issued to all cores
//   core_ready                 per-core ready_out  [2]=R [1]=G [0]=B
//   core_valid_out/data_out    per-core outputs
//   m_valid, m_data            output pixel stream, no backpressure
//   m_sof, m_eol               first pixel of frame / last pixel of row
// ---------------------------------------------------------------------------
module upscale_frame_ctrl
  import upscale_pkg::*;
#(
  parameter int bit_depth     = 8,
  parameter int h_res         = 4,
  parameter int v_res         = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [3*bit_depth-1:0] s_data,
  output logic                   core_rst,
  output logic                   core_valid_in,
  output logic [3*bit_depth-1:0] core_data_in,
  input  logic [2:0]             core_ready,
  input  logic [2:0]             core_valid_out,
  input  logic [3*bit_depth-1:0] core_data_out,
  output logic                   m_valid,
  output logic [3*bit_depth-1:0] m_data,
  output logic                   m_sof,
  output logic                   m_eol
);

  localparam int N_IN   = IN_PIX(h_res, v_res);
  localparam int N_OUT  = OUT_PIX(h_res, v_res);
  localparam int IN_W   = $clog2(N_IN + 1);
  localparam int OUT_W  = $clog2(N_OUT + 1);
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [IN_W-1:0]   IN_MAX    = IN_W'(N_IN);
  localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(N_IN - 1);
  localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(N_OUT);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(N_OUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  ctrl_state_t       state;
  logic [IN_W-1:0]   in_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic collecting;
  logic pix_all;
  logic pix_partial;
  logic emit;
  logic overflow;
  logic accept;
  logic pos_sof;
  logic pos_eol;

  // Core outputs are only meaningful while a frame is in flight.
  assign collecting  = (state == ST_RUN) || (state == ST_DRAIN);
  assign pix_all     = (core_valid_out == 3'b111);
  // Cores run in lockstep; any split between channels means they desynced.
  assign pix_partial = (core_valid_out != 3'b000) && !pix_all;
  assign emit        = collecting && pix_all && (out_cnt < OUT_MAX) && !abort;
  assign overflow    = collecting && pix_all && (out_cnt == OUT_MAX);

  // Input is issued only when every core can take it in the same cycle.
  assign s_ready       = (state == ST_RUN) && (&core_ready) && (in_cnt < IN_MAX);
  assign accept        = s_valid && s_ready;
  assign core_valid_in = accept;
  assign core_data_in  = s_data;

  frame_pos_counter #(
    .width  (2 * h_res),
    .height (2 * v_res)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_ARM),
    .inc   (emit),
    .sof   (pos_sof),
    .eol   (pos_eol)
  );

  always_ff @(posedge clk) begin
    // NOTE: nxt is a per-evaluation temporary, so it is assigned blocking and
    // read back within this same block; every real register uses <=.
    ctrl_state_t nxt;
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      core_rst   <= 1'b1;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      idle_cnt   <= '0;
    end else begin
      nxt = state;

      // Output stage: one-cycle registered copy of a full three-channel pixel.
      m_valid <= emit;
      m_sof   <= emit && pos_sof;
      m_eol   <= emit && pos_eol;
      if (emit) m_data <= core_data_out;

      if (accept) in_cnt  <= in_cnt + 1'b1;
      if (emit)   out_cnt <= out_cnt + 1'b1;

      // Stall watchdog counts only DRAIN cycles that produced no pixel.
      idle_cnt <= (state == ST_DRAIN && !emit) ? idle_cnt + 1'b1 : '0;

      if (abort) begin
        nxt = ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              nxt = ST_ARM;
              err <= 1'b0;
            end
          end
          ST_ARM: begin
            nxt = ST_RUN;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
          ST_RUN: begin
            if (pix_partial) begin
              err <= 1'b1;
              nxt = ST_IDLE;
            end else begin
              if (overflow) err <= 1'b1;
              if (accept && in_cnt == IN_LAST) nxt = ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (pix_partial) begin
              err <= 1'b1;
              nxt = ST_IDLE;
            end else if (overflow) begin
              err <= 1'b1;
            end else if (emit && out_cnt == OUT_LAST) begin
              nxt = ST_DONE;
            end else if (!emit && idle_cnt == IDLE_LAST) begin
              err <= 1'b1;
              nxt = ST_IDLE;
            end
          end
          ST_DONE: nxt = ST_IDLE;
          default: nxt = ST_IDLE;
        endcase
      end

      // Status outputs are registered from the state being entered.
      state      <= nxt;
      busy       <= (nxt != ST_IDLE);
      core_rst   <= (nxt == ST_IDLE) || (nxt == ST_ARM);
      frame_done <= (nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_upscale_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_upscale_frame_ctrl
//   Bench for upscale_frame_ctrl with h_res = v_res = 4. Three lockstep
//   nearest-neighbour 2x2 cores sit behind the controller: each buffers one
//   input row, then emits two output rows of 8 pixels. Output pixel (r,c)
//   must equal input pixel (r/2, c/2) of the same frame.
// ---------------------------------------------------------------------------
module tb_upscale_frame_ctrl;

  localparam int BD    = 8;
  localparam int H     = 4;
  localparam int V     = 4;
  localparam int N_IN  = H * V;
  localparam int N_OUT = 4 * H * V;
  localparam int OW    = 2 * H;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          busy;
  logic          frame_done;
  logic          err;
  logic          s_valid;
  logic          s_ready;
  logic [3*BD-1:0] s_data;
  logic          core_rst;
  logic          core_valid_in;
  logic [3*BD-1:0] core_data_in;
  logic [2:0]    core_ready;
  logic [2:0]    core_valid_out;
  logic [3*BD-1:0] core_data_out;
  logic          m_valid;
  logic [3*BD-1:0] m_data;
  logic          m_sof;
  logic          m_eol;

  upscale_frame_ctrl #(
    .bit_depth     (BD),
    .h_res         (H),
    .v_res         (V),
    .DRAIN_TIMEOUT (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .frame_done     (frame_done),
    .err            (err),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .core_rst       (core_rst),
    .core_valid_in  (core_valid_in),
    .core_data_in   (core_data_in),
    .core_ready     (core_ready),
    .core_valid_out (core_valid_out),
    .core_data_out  (core_data_out),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_sof          (m_sof),
    .m_eol          (m_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- core models (three channels in lockstep) ----------------
  logic [3*BD-1:0] cbuf [H];
  int              fill      = 0;
  int              eidx      = 0;
  logic            emitting  = 1'b0;
  logic            vout      = 1'b0;
  logic [3*BD-1:0] dout      = '0;
  logic            force_en;
  logic [2:0]      force_val;

  always @(posedge clk) begin
    if (core_rst) begin
      fill     <= 0;
      eidx     <= 0;
      emitting <= 1'b0;
      vout     <= 1'b0;
    end else begin
      vout <= 1'b0;
      if (emitting) begin
        vout <= 1'b1;
        dout <= cbuf[(eidx % OW) / 2];
        if (eidx == 2 * OW - 1) begin
          emitting <= 1'b0;
          eidx     <= 0;
          fill     <= 0;
        end else begin
          eidx <= eidx + 1;
        end
      end else if (core_valid_in) begin
        cbuf[fill] <= core_data_in;
        if (fill == H - 1) emitting <= 1'b1;
        else               fill     <= fill + 1;
      end
    end
  end

  assign core_ready     = {3{~emitting}};
  assign core_valid_out = force_en ? force_val : {3{vout}};
  assign core_data_out  = dout;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3*BD-1:0] pix(input int k);
    return {8'(k), 8'(k + 16), 8'(255 - k)};
  endfunction

  // Frame model: input pixels captured on accept, output pixels predicted
  // from their raster position in the 2x-upscaled frame.
  logic [3*BD-1:0] in_pix  [N_IN];
  logic [3*BD-1:0] out_log [N_OUT];
  logic [3*BD-1:0] ref_log [N_OUT];
  int n_out  = 0;
  int n_acc  = 0;
  int n_sof  = 0;
  int n_eol  = 0;
  int n_done = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      if (n_out < N_OUT) begin
        int r;
        int c;
        r = n_out / OW;
        c = n_out % OW;
        check("m_data", m_data, in_pix[(r / 2) * H + c / 2]);
        check("m_sof", m_sof, n_out == 0);
        check("m_eol", m_eol, c == OW - 1);
        out_log[n_out] = m_data;
      end else begin
        check("pixel_overrun", n_out, N_OUT - 1);
      end
      n_out++;
      if (m_sof) n_sof++;
      if (m_eol) n_eol++;
    end else begin
      check("flags_without_valid", {m_sof, m_eol}, 2'b00);
    end
    if (frame_done) n_done++;
    if (s_valid && s_ready) begin
      if (n_acc < N_IN) in_pix[n_acc] = s_data;
      n_acc++;
    end
    // A start seen in IDLE opens a new frame for the model.
    if (start && !busy && !abort && !reset) begin
      n_out  = 0;
      n_acc  = 0;
      n_sof  = 0;
      n_eol  = 0;
      n_done = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
  endtask

  // Offer pixels until stop_after are accepted; optionally pulse start once.
  task automatic feed(input bit gaps, input int stop_after, input int start_at);
    int acc = 0;
    int cyc = 0;
    bit pulsed = 1'b0;
    bit take;
    while (acc < stop_after && cyc < 2000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = pix(acc);
      start   = 1'b0;
      if (acc == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      take = s_valid && s_ready;
      tick();
      cyc++;
      if (take) acc++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    check("feed_accepts", acc, stop_after);
  endtask

  // Keep offering input through the drain so a stray re-open would show.
  task automatic wait_done();
    int cyc = 0;
    s_valid = 1'b1;
    s_data  = pix(N_IN);
    while (n_done == 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("frame_done_seen", n_done > 0, 1'b1);
    repeat (2) tick();
    s_valid = 1'b0;
  endtask

  task automatic frame_checks();
    check("accept_count", n_acc, N_IN);
    check("pixel_count", n_out, N_OUT);
    check("eol_count", n_eol, 2 * V);
    check("sof_count", n_sof, 1);
    check("frame_done_count", n_done, 1);
    check("err_clean", err, 1'b0);
    check("idle_after_frame", busy, 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_core_valid_in", core_valid_in, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_sof", m_sof, 1'b0);
    check("rst_m_eol", m_eol, 1'b0);
    check("rst_core_rst", core_rst, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    force_en  = 1'b0;
    force_val = 3'b000;
    repeat (3) tick();
    check_reset_values();
    reset = 1'b0;
    tick();

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 1'b0);

    // ramp frame, s_valid held high
    start_frame();
    feed(1'b0, N_IN, -1);
    wait_done();
    frame_checks();
    ref_log = out_log;
    check("pin_pix0", ref_log[0], 24'h0010FF);
    check("pin_pix9", ref_log[9], 24'h0010FF);
    check("pin_pix18", ref_log[18], 24'h0515FA);
    check("pin_pix63", ref_log[63], 24'h0F1FF0);

    // random input gaps give the identical output frame
    start_frame();
    feed(1'b1, N_IN, -1);
    wait_done();
    frame_checks();
    for (int i = 0; i < N_OUT; i++) check("gap_vs_ramp", out_log[i], ref_log[i]);

    // start pulsed during RUN is ignored
    start_frame();
    feed(1'b0, N_IN, 8);
    wait_done();
    frame_checks();

    // abort after 7 accepts
    start_frame();
    feed(1'b0, 7, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_core_rst", core_rst, 1'b1);
    repeat (6) tick();
    check("abort_no_done", n_done, 0);
    start_frame();
    feed(1'b0, N_IN, -1);
    wait_done();
    frame_checks();

    // one-cycle partial core_valid_out in DRAIN
    start_frame();
    feed(1'b0, N_IN, -1);
    repeat (3) tick();
    force_en  = 1'b1;
    force_val = 3'b110;
    tick();
    force_en = 1'b0;
    check("partial_err", err, 1'b1);
    check("partial_idle", busy, 1'b0);
    check("partial_no_pixel", m_valid, 1'b0);
    repeat (10) tick();
    check("partial_err_sticky", err, 1'b1);
    start_frame();
    check("err_cleared_by_start", err, 1'b0);
    feed(1'b0, N_IN, -1);
    wait_done();
    frame_checks();

    // drain stall timeout
    start_frame();
    feed(1'b0, N_IN, -1);
    force_en  = 1'b1;
    force_val = 3'b000;
    cnt = 0;
    while (!err && cnt < 200) begin
      tick();
      cnt++;
    end
    force_en = 1'b0;
    check("timeout_cycles", cnt, 64);
    check("timeout_err", err, 1'b1);
    check("timeout_idle", busy, 1'b0);

    // reset in the middle of DRAIN
    start_frame();
    feed(1'b0, N_IN, -1);
    repeat (2) tick();
    check("drain_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
